multihot_index_encoder: RTL and testbench

- Inverse of the decoder-style blocks: turns a multi-hot minterm/request vector back into binary index codes.
- Accepts one N-bit vector per valid/ready transaction and emits one index beat per set bit, in priority order, on a valid/ready output stream.
- An all-zero vector produces a single "none" beat.
- Sits between any minterm/request generator and downstream logic that consumes binary codes, one per cycle.

---
 rtl/multihot_enc_pkg.sv | 23 ++
 rtl/multihot_index_encoder_pri_encoder.sv | 52 +++++
 rtl/multihot_index_encoder.sv | 118 +++++++++++
 tb/tb_multihot_index_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multihot_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multihot_enc_pkg
//  Description : Shared types and helpers for the multi-hot index encoder.
//                - state_e     : controller state (IDLE / EMIT)
//                - safe_clog2  : index width helper that never returns 0
//  Revision    : 1.0 - initial release
// ============================================================================
package multihot_enc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // Width of a binary index able to address n positions. A 1-wide vector
   // still needs a 1-bit index port, so the result is clamped to at least 1.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multihot_index_encoder_pri_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : pri_encoder_n
//  Description : Combinational priority encoder over an N-bit vector.
//                Reports the position of the lowest (LSB_FIRST=1) or highest
//                (LSB_FIRST=0) set bit, and whether exactly one bit is set.
//  Ports       : vec         in  [N-1:0]  vector to encode
//                index       out [W-1:0]  winning bit position (0 if vec==0)
//                onehot_only out          popcount(vec) == 1
//  Revision    : 1.0 - initial release
// ============================================================================
module pri_encoder_n
   import multihot_enc_pkg::*;
#(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int W         = safe_clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] index,
   output logic         onehot_only
);

   // The loop scans toward the preferred end so that the last assignment
   // made is the winning bit; no explicit break is needed.
   generate
      if (LSB_FIRST) begin : g_lsb_first
         always_comb begin
            index = '0;
            for (int i = N - 1; i >= 0; i--) begin
               if (vec[i]) begin
                  index = W'(i);
               end
            end
         end
      end else begin : g_msb_first
         always_comb begin
            index = '0;
            for (int i = 0; i < N; i++) begin
               if (vec[i]) begin
                  index = W'(i);
               end
            end
         end
      end
   endgenerate

   // Clearing the lowest set bit leaves zero exactly when one bit was set.
   assign onehot_only = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/multihot_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : multihot_index_encoder
//  Description : Accepts one multi-hot vector per in_valid/in_ready transfer
//                and emits one beat per set bit, in priority order, on an
//                out_valid/out_ready stream. An all-zero vector yields one
//                "none" beat. Outputs are driven from registers only.
//  Ports       : clk        in           rising-edge clock
//                rst        in           asynchronous active-high reset
//                in_valid   in           in_vec is valid
//                in_ready   out          block can accept a vector
//                in_vec     in  [N-1:0]  multi-hot vector
//                out_valid  out          beat fields are valid
//                out_ready  in           downstream takes the current beat
//                out_idx    out [W-1:0]  index of the current set bit
//                out_last   out          final beat of this vector
//                out_none   out          vector was all zeros
//                out_count  out [W-1:0]  0-based beat number within vector
//  Revision    : 1.0 - initial release
// ============================================================================
module multihot_index_encoder
   import multihot_enc_pkg::*;
#(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1,
   localparam int W        = safe_clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_none,
   output logic [W-1:0] out_count
);

   localparam logic [0:0] S_IDLE = ST_IDLE;
   localparam logic [0:0] S_EMIT = ST_EMIT;

   logic [0:0]   state_q, state_d;
   logic [N-1:0] pend_q,  pend_d;    // bits still to be emitted
   logic         zero_q,  zero_d;    // accepted vector was all zeros
   logic [W-1:0] cnt_q,   cnt_d;     // beat number within current vector

   logic [W-1:0] enc_idx;
   logic         enc_one;
   logic         emit;
   logic         beat_last;
   logic         beat_fire;
   logic         accept;

   pri_encoder_n #(
      .N         (N),
      .LSB_FIRST (LSB_FIRST),
      .W         (W)
   ) u_pri (
      .vec         (pend_q),
      .index       (enc_idx),
      .onehot_only (enc_one)
   );

   assign emit      = (state_q == S_EMIT);
   assign beat_last = zero_q | enc_one;
   assign beat_fire = emit & out_ready;
   // in_valid is only looked at while idle, so it is ignored during EMIT.
   assign accept    = ~emit & in_valid;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      if (accept) begin
         pend_d  = in_vec;
         zero_d  = (in_vec == '0);
         cnt_d   = '0;
         state_d = S_EMIT;
      end else if (beat_fire) begin
         pend_d = pend_q & ~(N'(1) << enc_idx);
         if (beat_last) begin
            state_d = S_IDLE;
         end else begin
            // Held on the last beat so the counter stays within N-1 even
            // for a full vector of N beats.
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
      end
   end

   // Beat fields are forced to zero outside EMIT so idle and reset show a
   // quiet bus regardless of stale register contents.
   assign in_ready  = ~emit;
   assign out_valid = emit;
   assign out_idx   = (emit && !zero_q) ? enc_idx : '0;
   assign out_last  = emit & beat_last;
   assign out_none  = emit & zero_q;
   assign out_count = emit ? cnt_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_multihot_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multihot_index_encoder
//  Description : Bench for multihot_index_encoder. Instance 0 uses
//                LSB_FIRST=1, instance 1 uses LSB_FIRST=0, both N=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multihot_index_encoder;

   typedef struct packed {
      logic [2:0] idx;
      logic       last;
      logic       none;
      logic [2:0] cnt;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      in_valid_a  = '0;
   logic [1:0][7:0] in_vec_a    = '0;
   logic [1:0]      out_ready_a = 2'b11;
   logic [1:0]      in_ready_a;
   logic [1:0]      out_valid_a;
   logic [1:0][2:0] out_idx_a;
   logic [1:0]      out_last_a;
   logic [1:0]      out_none_a;
   logic [1:0][2:0] out_count_a;

   int n_checks = 0;
   int n_fail   = 0;

   beat_t q0[$];
   beat_t q1[$];
   int    obs0[$];
   int    obs1[$];

   always #5 clk = ~clk;

   multihot_index_encoder #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_vec(in_vec_a[0]),
      .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
      .out_idx(out_idx_a[0]), .out_last(out_last_a[0]),
      .out_none(out_none_a[0]), .out_count(out_count_a[0])
   );

   multihot_index_encoder #(.N(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_vec(in_vec_a[1]),
      .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
      .out_idx(out_idx_a[1]), .out_last(out_last_a[1]),
      .out_none(out_none_a[1]), .out_count(out_count_a[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Expected beats of a vector: the set-bit positions listed in emission
   // order, numbered 0.., last flag on the final one; none-beat if empty.
   task automatic push_beats(input int d, input logic [7:0] v);
      int    pos[$];
      beat_t b;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            if (d == 0) pos.push_back(i);
            else        pos.push_front(i);
         end
      end
      if (pos.size() == 0) begin
         b = '{idx: 3'd0, last: 1'b1, none: 1'b1, cnt: 3'd0};
         if (d == 0) q0.push_back(b); else q1.push_back(b);
      end else begin
         for (int k = 0; k < pos.size(); k++) begin
            b.idx  = 3'(pos[k]);
            b.last = (k == pos.size() - 1);
            b.none = 1'b0;
            b.cnt  = 3'(k);
            if (d == 0) q0.push_back(b); else q1.push_back(b);
         end
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (qsize(d) != 0) begin
               if (out_ready_a[d]) begin
                  if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               end
            end else if (in_valid_a[d]) begin
               push_beats(d, in_vec_a[d]);
            end
         end
      end
   end

   // Observed handshakes, used for literal sequence checks.
   always @(posedge clk) begin
      if (!rst) begin
         if (out_valid_a[0] && out_ready_a[0]) obs0.push_back(int'(out_idx_a[0]));
         if (out_valid_a[1] && out_ready_a[1]) obs1.push_back(int'(out_idx_a[1]));
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         beat_t h;
         chk($sformatf("out_valid[%0d]", d), int'(out_valid_a[d]), int'(qsize(d) != 0));
         chk($sformatf("in_ready[%0d]", d), int'(in_ready_a[d]), int'(qsize(d) == 0));
         if (qsize(d) != 0) begin
            h = (d == 0) ? q0[0] : q1[0];
            chk($sformatf("out_idx[%0d]", d),   int'(out_idx_a[d]),   int'(h.idx));
            chk($sformatf("out_last[%0d]", d),  int'(out_last_a[d]),  int'(h.last));
            chk($sformatf("out_none[%0d]", d),  int'(out_none_a[d]),  int'(h.none));
            chk($sformatf("out_count[%0d]", d), int'(out_count_a[d]), int'(h.cnt));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle(input int d);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready_a[d] && k < 40);
      chk("idle_timeout", int'(in_ready_a[d]), 1);
   endtask

   // Returns at the negedge where the first beat of v is visible.
   task automatic send(input int d, input logic [7:0] v);
      wait_idle(d);
      in_valid_a[d] = 1'b1;
      in_vec_a[d]   = v;
      @(negedge clk);
      in_valid_a[d] = 1'b0;
      in_vec_a[d]   = 8'($urandom);
   endtask

   task automatic chk_seq(input string name, input int d, input int exp[$]);
      int got[$];
      got = (d == 0) ? obs0 : obs1;
      chk({name, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_beat%0d", name, i), got[i], exp[i]);
   endtask

   task automatic chk_reset_outputs(input int d);
      chk($sformatf("rst_valid[%0d]", d), int'(out_valid_a[d]), 0);
      chk($sformatf("rst_ready[%0d]", d), int'(in_ready_a[d]),  1);
      chk($sformatf("rst_idx[%0d]", d),   int'(out_idx_a[d]),   0);
      chk($sformatf("rst_last[%0d]", d),  int'(out_last_a[d]),  0);
      chk($sformatf("rst_none[%0d]", d),  int'(out_none_a[d]),  0);
      chk($sformatf("rst_count[%0d]", d), int'(out_count_a[d]), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      chk_reset_outputs(0);
      chk_reset_outputs(1);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // LSB first, full-rate drain.
      obs0.delete();
      send(0, 8'b1001_0110);
      chk("t1_first_idx", int'(out_idx_a[0]), 1);
      wait_idle(0);
      chk_seq("t1_seq", 0, '{1, 2, 4, 7});

      // Stall on the second beat for three cycles.
      obs0.delete();
      send(0, 8'b1001_0110);
      @(negedge clk);
      out_ready_a[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_stall_idx",   int'(out_idx_a[0]),   2);
         chk("t2_stall_count", int'(out_count_a[0]), 1);
         chk("t2_stall_last",  int'(out_last_a[0]),  0);
         @(negedge clk);
      end
      out_ready_a[0] = 1'b1;
      wait_idle(0);
      chk_seq("t2_seq", 0, '{1, 2, 4, 7});

      // All-zero vector: one none-beat, then idle.
      send(0, 8'h00);
      chk("t3_none",  int'(out_none_a[0]),  1);
      chk("t3_idx",   int'(out_idx_a[0]),   0);
      chk("t3_last",  int'(out_last_a[0]),  1);
      chk("t3_count", int'(out_count_a[0]), 0);
      @(negedge clk);
      chk("t3_idle_ready", int'(in_ready_a[0]),  1);
      chk("t3_idle_valid", int'(out_valid_a[0]), 0);

      // MSB first, full vector.
      obs1.delete();
      send(1, 8'hFF);
      wait_idle(1);
      chk_seq("t4_seq", 1, '{7, 6, 5, 4, 3, 2, 1, 0});

      // Asynchronous reset after two beats.
      obs1.delete();
      send(1, 8'hFF);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_valid", int'(out_valid_a[1]), 0);
      chk("t5_async_ready", int'(in_ready_a[1]),  1);
      chk_seq("t5_pre_rst", 1, '{7, 6});
      @(negedge clk);
      rst = 1'b0;
      obs1.delete();
      send(1, 8'b0000_1000);
      chk("t5_idx",  int'(out_idx_a[1]),  3);
      chk("t5_last", int'(out_last_a[1]), 1);
      wait_idle(1);
      chk_seq("t5_seq", 1, '{3});

      // in_valid with changing in_vec during EMIT must be ignored.
      obs0.delete();
      send(0, 8'b1001_0110);
      for (int k = 0; k < 3; k++) begin
         in_valid_a[0] = 1'b1;
         in_vec_a[0]   = 8'($urandom);
         chk("t6_busy_ready", int'(in_ready_a[0]), 0);
         @(negedge clk);
      end
      in_valid_a[0] = 1'b0;
      chk("t6_last_beat", int'(out_last_a[0]), 1);
      wait_idle(0);
      chk_seq("t6_seq", 0, '{1, 2, 4, 7});

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
